// File: rtl/oam_scan_control.sv
// Per-line OAM scan: walks entries 0..N_ENTRIES-1 and fills the sprite store.
// Optional OAM_SCAN_EARLY_EXIT_EN: the scan ends at the write that fills the store.
module oam_scan_control #(
    parameter int N_ENTRIES = 40,
    parameter int N_SLOTS   = 10
) (
    input  logic       clk1,
    input  logic       reset_video,
    input  logic       line_start,
    input  logic       ff40_d2,
    input  logic [7:0] v,
    input  logic [7:0] oam_y,
    input  logic [7:0] oam_x,
    output logic [5:0] oam_idx,
    output logic       oam_rd,
    output logic       store_we,
    output logic [3:0] store_slot,
    output logic [5:0] store_idx,
    output logic [3:0] store_row,
    output logic [7:0] store_x,
    output logic [3:0] spr_count,
    output logic       scan_busy,
    output logic       scan_done
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        CMP,
        DONE
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(N_ENTRIES - 1);
    localparam logic [3:0] FULL_CNT = 4'(N_SLOTS);

    state_t     state;
    logic [8:0] diff;
    logic [8:0] height;
    logic       hit;
    logic       last;

    // Y test against the live line/size; the write is dropped on a restart.
    always_comb begin
        diff     = {1'b0, v} + 9'd16 - {1'b0, oam_y};
        height   = ff40_d2 ? 9'd16 : 9'd8;
        hit      = diff < height;
        store_we = (state == CMP) && hit && (spr_count != FULL_CNT)
                   && !line_start;
`ifdef OAM_SCAN_EARLY_EXIT_EN
        last     = (oam_idx == LAST_IDX)
                   || (store_we && (spr_count == FULL_CNT - 4'd1));
`else
        last     = (oam_idx == LAST_IDX);
`endif
    end

    // Store-side payload is zeroed whenever no write is issued.
    always_comb begin
        store_slot = 4'd0;
        store_idx  = 6'd0;
        store_row  = 4'd0;
        store_x    = 8'd0;
        if (store_we) begin
            store_slot = spr_count;
            store_idx  = oam_idx;
            store_row  = diff[3:0];
            store_x    = oam_x;
        end
    end

    // Scan sequencer with registered handshake and status outputs.
    always_ff @(posedge clk1 or posedge reset_video) begin
        if (reset_video) begin
            state     <= IDLE;
            oam_idx   <= 6'd0;
            oam_rd    <= 1'b0;
            spr_count <= 4'd0;
            scan_busy <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (line_start) begin
                state     <= ADDR;
                oam_idx   <= 6'd0;
                spr_count <= 4'd0;
                oam_rd    <= 1'b1;
                scan_busy <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    ADDR: begin
                        state  <= CMP;
                        oam_rd <= 1'b0;
                    end
                    CMP: begin
                        if (store_we) begin
                            spr_count <= spr_count + 4'd1;
                        end
                        if (last) begin
                            state     <= DONE;
                            scan_busy <= 1'b0;
                            scan_done <= 1'b1;
                        end else begin
                            state   <= ADDR;
                            oam_idx <= oam_idx + 6'd1;
                            oam_rd  <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oam_scan_control.sv
// Directed bench for oam_scan_control: single-entry vector table,
// slot overflow, mid-scan restart and mid-scan reset.
module tb_oam_scan_control;

    logic       clk1 = 1'b0;
    logic       reset_video;
    logic       line_start;
    logic       ff40_d2;
    logic [7:0] v;
    logic [7:0] oam_y;
    logic [7:0] oam_x;
    logic [5:0] oam_idx;
    logic       oam_rd;
    logic       store_we;
    logic [3:0] store_slot;
    logic [5:0] store_idx;
    logic [3:0] store_row;
    logic [7:0] store_x;
    logic [3:0] spr_count;
    logic       scan_busy;
    logic       scan_done;

    oam_scan_control dut (
        .clk1       (clk1),
        .reset_video(reset_video),
        .line_start (line_start),
        .ff40_d2    (ff40_d2),
        .v          (v),
        .oam_y      (oam_y),
        .oam_x      (oam_x),
        .oam_idx    (oam_idx),
        .oam_rd     (oam_rd),
        .store_we   (store_we),
        .store_slot (store_slot),
        .store_idx  (store_idx),
        .store_row  (store_row),
        .store_x    (store_x),
        .spr_count  (spr_count),
        .scan_busy  (scan_busy),
        .scan_done  (scan_done)
    );

    always #5 clk1 = ~clk1;

    logic [7:0] mem_y [64];
    logic [7:0] mem_x [64];

    // OAM model: one-cycle read latency.
    always @(posedge clk1) begin
        if (oam_rd) begin
            oam_y <= mem_y[oam_idx];
            oam_x <= mem_x[oam_idx];
        end
    end

    int total = 0;
    int bad   = 0;

    int wr_cnt;
    int done_cyc;
    int rs_sc;
    int rs_idx;
    int w_slot [16];
    int w_idx  [16];
    int w_row  [16];
    int w_x    [16];

    typedef struct {
        logic [7:0] v;
        logic       sz;
        int         idx;
        logic [7:0] y;
        logic [7:0] x;
        int         we;
        int         row;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) begin
            mem_y[i] = 8'd0;
            mem_x[i] = 8'd0;
        end
    endtask

    task automatic run_scan(input int restart_at);
        int  cyc;
        bit  rs_pending;
        wr_cnt   = 0;
        done_cyc = -1;
        rs_sc    = -1;
        rs_idx   = -1;
        @(negedge clk1);
        line_start = 1'b1;
        @(negedge clk1);
        line_start = 1'b0;
        cyc        = 1;
        rs_pending = (restart_at > 0);
        while (cyc <= 200) begin
            if (store_we) begin
                if (wr_cnt < 16) begin
                    w_slot[wr_cnt] = int'(store_slot);
                    w_idx[wr_cnt]  = int'(store_idx);
                    w_row[wr_cnt]  = int'(store_row);
                    w_x[wr_cnt]    = int'(store_x);
                end
                wr_cnt++;
            end
            if (scan_done) begin
                done_cyc = cyc;
                break;
            end
            if (rs_pending && cyc == restart_at) begin
                line_start = 1'b1;
                @(negedge clk1);
                line_start = 1'b0;
                rs_pending = 1'b0;
                wr_cnt     = 0;
                cyc        = 1;
                rs_sc      = int'(spr_count);
                rs_idx     = int'(oam_idx);
                continue;
            end
            @(negedge clk1);
            cyc++;
        end
    endtask

    initial begin
        int exp_done;
        int seen_done;
        int seen_we;

        reset_video = 1'b1;
        line_start  = 1'b0;
        ff40_d2     = 1'b0;
        v           = 8'd0;
        oam_y       = 8'd0;
        oam_x       = 8'd0;
        clear_mem();

        vt[0] = '{v: 8'd20,  sz: 1'b0, idx: 5,  y: 8'd30,  x: 8'h44, we: 1, row: 6};
        vt[1] = '{v: 8'd20,  sz: 1'b0, idx: 7,  y: 8'd26,  x: 8'h12, we: 0, row: 0};
        vt[2] = '{v: 8'd20,  sz: 1'b1, idx: 7,  y: 8'd26,  x: 8'h12, we: 1, row: 10};
        vt[3] = '{v: 8'd0,   sz: 1'b1, idx: 39, y: 8'd0,   x: 8'h55, we: 0, row: 0};
        vt[4] = '{v: 8'd0,   sz: 1'b0, idx: 39, y: 8'd9,   x: 8'hAB, we: 1, row: 7};
        vt[5] = '{v: 8'd0,   sz: 1'b0, idx: 0,  y: 8'd8,   x: 8'h01, we: 0, row: 0};
        vt[6] = '{v: 8'd100, sz: 1'b0, idx: 20, y: 8'd200, x: 8'h02, we: 0, row: 0};
        vt[7] = '{v: 8'd143, sz: 1'b1, idx: 0,  y: 8'd144, x: 8'hFF, we: 1, row: 15};
        vt[8] = '{v: 8'd255, sz: 1'b1, idx: 3,  y: 8'd255, x: 8'h77, we: 0, row: 0};

        @(negedge clk1);
        chk("rst_oam_idx", int'(oam_idx), 0);
        chk("rst_oam_rd", int'(oam_rd), 0);
        chk("rst_store_we", int'(store_we), 0);
        chk("rst_store_slot", int'(store_slot), 0);
        chk("rst_store_idx", int'(store_idx), 0);
        chk("rst_store_row", int'(store_row), 0);
        chk("rst_store_x", int'(store_x), 0);
        chk("rst_spr_count", int'(spr_count), 0);
        chk("rst_scan_busy", int'(scan_busy), 0);
        chk("rst_scan_done", int'(scan_done), 0);
        reset_video = 1'b0;
        @(negedge clk1);

        for (int k = 0; k < 9; k++) begin
            clear_mem();
            mem_y[vt[k].idx] = vt[k].y;
            mem_x[vt[k].idx] = vt[k].x;
            v       = vt[k].v;
            ff40_d2 = vt[k].sz;
            run_scan(0);
            chk($sformatf("v%0d_writes", k), wr_cnt, vt[k].we);
            chk($sformatf("v%0d_done_cyc", k), done_cyc, 81);
            chk($sformatf("v%0d_spr_count", k), int'(spr_count), vt[k].we);
            if (vt[k].we == 1 && wr_cnt == 1) begin
                chk($sformatf("v%0d_slot", k), w_slot[0], 0);
                chk($sformatf("v%0d_idx", k), w_idx[0], vt[k].idx);
                chk($sformatf("v%0d_row", k), w_row[0], vt[k].row);
                chk($sformatf("v%0d_x", k), w_x[0], int'(vt[k].x));
            end
            @(negedge clk1);
            chk($sformatf("v%0d_busy_after", k), int'(scan_busy), 0);
            chk($sformatf("v%0d_done_pulse", k), int'(scan_done), 0);
        end

        // Overflow: 12 matches, only 10 stored.
        clear_mem();
        for (int i = 0; i < 12; i++) begin
            mem_y[i] = 8'd30;
            mem_x[i] = 8'(8'h80 + i);
        end
        v       = 8'd20;
        ff40_d2 = 1'b0;
`ifdef OAM_SCAN_EARLY_EXIT_EN
        exp_done = 21;
`else
        exp_done = 81;
`endif
        run_scan(0);
        chk("ovf_writes", wr_cnt, 10);
        chk("ovf_done_cyc", done_cyc, exp_done);
        chk("ovf_spr_count", int'(spr_count), 10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("ovf_slot%0d", i), w_slot[i], i);
            chk($sformatf("ovf_idx%0d", i), w_idx[i], i);
            chk($sformatf("ovf_x%0d", i), w_x[i], 8'h80 + i);
        end
        @(negedge clk1);

        // Restart at cycle 41 after 3 entries stored.
        clear_mem();
        for (int i = 0; i < 3; i++) begin
            mem_y[i] = 8'd30;
            mem_x[i] = 8'(8'h10 + i);
        end
        run_scan(41);
        chk("rs_spr_count_cleared", rs_sc, 0);
        chk("rs_oam_idx_cleared", rs_idx, 0);
        chk("rs_done_cyc", done_cyc, 81);
        chk("rs_writes", wr_cnt, 3);
        chk("rs_spr_count_end", int'(spr_count), 3);
        @(negedge clk1);

        // Reset asserted at cycle 30 of a scan full of matches.
        for (int i = 0; i < 40; i++) begin
            mem_y[i] = 8'd30;
        end
        line_start = 1'b1;
        @(negedge clk1);
        line_start = 1'b0;
        for (int c = 1; c < 30; c++) @(negedge clk1);
        reset_video = 1'b1;
        #1;
        chk("mrst_spr_count", int'(spr_count), 0);
        chk("mrst_scan_busy", int'(scan_busy), 0);
        chk("mrst_oam_rd", int'(oam_rd), 0);
        chk("mrst_oam_idx", int'(oam_idx), 0);
        chk("mrst_store_we", int'(store_we), 0);
        @(negedge clk1);
        chk("mrst_next_busy", int'(scan_busy), 0);
        chk("mrst_next_done", int'(scan_done), 0);
        chk("mrst_next_store_x", int'(store_x), 0);
        reset_video = 1'b0;
        seen_done = 0;
        seen_we   = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk1);
            if (scan_done) seen_done++;
            if (store_we) seen_we++;
            if (scan_busy) seen_we++;
        end
        chk("mrst_no_done", seen_done, 0);
        chk("mrst_idle_quiet", seen_we, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
